binario_bcd_seq: RTL

- Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Replaces the purely combinational divide/modulo converter for wider operands, where `/` and `%` synthesise poorly.
- Adds a start/busy/done handshake, a configurable digit count and optional two's-complement input (sign flag plus magnitude).
- Sits between arithmetic/counter blocks and the 7-segment digit drivers.

---
 rtl/binario_bcd_seq_if.sv | 23 ++
 rtl/binario_bcd_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/binario_bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// The master issues start/binario; the slave returns busy/done/bcd/negativo.
interface binario_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      binario;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  negativo;

  modport master (
    output start, binario,
    input  busy, done, bcd, negativo
  );

  modport slave (
    input  start, binario,
    output busy, done, bcd, negativo
  );
endinterface

// File: rtl/binario_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Optional two's-complement input converted as sign flag plus magnitude.
module binario_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter bit SIGNED = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  binario_bcd_seq_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic bit cfg_ok();
    longint unsigned p;
    p = 1;
    if (DIGITS < 1) return 1'b0;
    if (DIGITS >= 10) return 1'b1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    return p > ((64'd1 << WIDTH) - 64'd1);
  endfunction

  localparam bit CFG_OK = cfg_ok();

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("binario_bcd_seq: WIDTH must be 4..32");
  end

  if (!CFG_OK) begin : g_bad_digits
    $error("binario_bcd_seq: DIGITS too small for WIDTH");
  end

  typedef enum logic {
    IDLE,
    CONV
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    scr_q, scr_d;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;
  logic             in_neg;
  logic             unused_msb;

  assign in_neg = SIGNED && bus.binario[WIDTH-1];

  // The top digit never reaches 5 for a legal DIGITS, so its MSB is always 0.
  assign unused_msb = adj[BW-1];

  always_comb begin
    adj = scr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    scr_d   = scr_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CONV;
          scr_d   = '0;
          mag_d   = in_neg ? (~bus.binario + WIDTH'(1))
                           : bus.binario;
          cnt_d   = CW'(WIDTH);
          sign_d  = in_neg;
        end
      end
      CONV: begin
        scr_d = {adj[BW-2:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          bcd_d   = scr_d;
          neg_d   = sign_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      scr_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = (state_q == CONV);
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.negativo = neg_q;

endmodule
